// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller: turns a resolved taken branch from EX into a fetch
// redirect handshake followed by a fixed-length pipeline flush.
module branch_redirect_ctrl #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        br_valid_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        redir_ready_i,
    output logic        redir_valid_o,
    output logic [31:0] redir_pc_o,
    output logic        flush_o,
    output logic        busy_o,
    output logic        misalign_o,
    output logic [31:0] misalign_addr_o,
    output logic [31:0] br_cnt_o,
    output logic [31:0] taken_cnt_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } state_e;

    localparam int         FLUSH_LOAD_INT = (FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0;
    localparam logic [3:0] FLUSH_LOAD     = FLUSH_LOAD_INT[3:0];

    state_e      state_q, state_d;
    logic        redir_valid_q, redir_valid_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic        flush_q, flush_d;
    logic        busy_q, busy_d;
    logic        misalign_q, misalign_d;
    logic [31:0] misalign_addr_q, misalign_addr_d;
    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] taken_cnt_q, taken_cnt_d;
    logic [3:0]  fcnt_q, fcnt_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            redir_valid_q   <= 1'b0;
            redir_pc_q      <= 32'd0;
            flush_q         <= 1'b0;
            busy_q          <= 1'b0;
            misalign_q      <= 1'b0;
            misalign_addr_q <= 32'd0;
            br_cnt_q        <= 32'd0;
            taken_cnt_q     <= 32'd0;
            fcnt_q          <= 4'd0;
        end else begin
            state_q         <= state_d;
            redir_valid_q   <= redir_valid_d;
            redir_pc_q      <= redir_pc_d;
            flush_q         <= flush_d;
            busy_q          <= busy_d;
            misalign_q      <= misalign_d;
            misalign_addr_q <= misalign_addr_d;
            br_cnt_q        <= br_cnt_d;
            taken_cnt_q     <= taken_cnt_d;
            fcnt_q          <= fcnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        redir_valid_d   = redir_valid_q;
        redir_pc_d      = redir_pc_q;
        flush_d         = flush_q;
        busy_d          = busy_q;
        misalign_d      = 1'b0;
        misalign_addr_d = misalign_addr_q;
        br_cnt_d        = br_cnt_q;
        taken_cnt_d     = taken_cnt_q;
        fcnt_d          = fcnt_q;
        case (state_q)
            IDLE: begin
                if (br_valid_i) begin
                    br_cnt_d = br_cnt_q + 32'd1;
                    if (br_taken_i) begin
                        if (br_target_i[1:0] == 2'b00) begin
                            state_d       = REDIRECT;
                            redir_valid_d = 1'b1;
                            redir_pc_d    = br_target_i;
                            flush_d       = 1'b1;
                            busy_d        = 1'b1;
                            taken_cnt_d   = taken_cnt_q + 32'd1;
                        end else begin
                            misalign_d      = 1'b1;
                            misalign_addr_d = br_target_i;
                        end
                    end
                end
            end
            REDIRECT: begin
                if (redir_ready_i) begin
                    redir_valid_d = 1'b0;
                    if (FLUSH_CYCLES > 0) begin
                        state_d = FLUSH;
                        fcnt_d  = FLUSH_LOAD;
                    end else begin
                        state_d = IDLE;
                        flush_d = 1'b0;
                        busy_d  = 1'b0;
                    end
                end
            end
            FLUSH: begin
                // Counter reaching zero means the last flush cycle is the current one.
                if (fcnt_q == 4'd0) begin
                    state_d = IDLE;
                    flush_d = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    fcnt_d = fcnt_q - 4'd1;
                end
            end
            default: begin
                state_d       = IDLE;
                redir_valid_d = 1'b0;
                flush_d       = 1'b0;
                busy_d        = 1'b0;
            end
        endcase
    end

    assign redir_valid_o   = redir_valid_q;
    assign redir_pc_o      = redir_pc_q;
    assign flush_o         = flush_q;
    assign busy_o          = busy_q;
    assign misalign_o      = misalign_q;
    assign misalign_addr_o = misalign_addr_q;
    assign br_cnt_o        = br_cnt_q;
    assign taken_cnt_o     = taken_cnt_q;

endmodule
